adder_mp_seq: RTL and testbench

- Multi-precision add/subtract sequencer that time-shares one external 8-bit ripple adder across NWORDS byte slices.
- Adder interface: a/b byte operands, carry-in, sum and cout.
- Accepts wide operands through a valid/ready request, feeds one byte slice per cycle LSB-first, chains the carry in a register, and returns the assembled result with carry/overflow/zero flags through a valid/ready response.
- Sits between the arithmetic issue logic and the shared gate-level adder.

---
 rtl/adder_mp_seq.sv | 87 ++++++++
 tb/tb_adder_mp_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_mp_seq.sv
// adder_mp_seq: multi-precision add/subtract sequencer time-sharing one external 8-bit adder
module adder_mp_seq #(
    parameter int NWORDS = 4,
    parameter int IDXW   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_sub,
    input  logic                req_cin,
    input  logic [8*NWORDS-1:0] req_a,
    input  logic [8*NWORDS-1:0] req_b,
    output logic [7:0]          add_a,
    output logic [7:0]          add_b,
    output logic                add_c,
    input  logic [7:0]          add_s,
    input  logic                add_cout,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [8*NWORDS-1:0] rsp_sum,
    output logic                rsp_cout,
    output logic                rsp_ovf,
    output logic                rsp_zero,
    output logic                busy
);
    localparam int W = 8 * NWORDS;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    a_r, bx_r, sum_r;
    logic [IDXW-1:0] idx;
    logic            carry, ovf_r, last;

    assign last = idx == IDXW'(NWORDS - 1);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // next-state: accept in IDLE, one slice per RUN cycle, hold result until taken
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req_valid ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = rsp_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // operand latch, per-slice accumulation and carry chaining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            bx_r  <= '0;
            sum_r <= '0;
            idx   <= '0;
            carry <= 1'b0;
            ovf_r <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            a_r   <= req_a;
            bx_r  <= req_b ^ {W{req_sub}};
            carry <= req_sub | req_cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_r[8*idx +: 8] <= add_s;
            carry             <= add_cout;
            if (!last) idx <= idx + 1'b1;
            if (last) ovf_r <= (a_r[W-1] == bx_r[W-1]) && (add_s[7] != a_r[W-1]);
        end
    end

    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign rsp_valid = state == DONE;
    assign add_a     = state == RUN ? a_r[8*idx +: 8] : 8'd0;
    assign add_b     = state == RUN ? bx_r[8*idx +: 8] : 8'd0;
    assign add_c     = state == RUN ? carry : 1'b0;
    assign rsp_sum   = sum_r;
    assign rsp_cout  = carry;
    assign rsp_ovf   = ovf_r;
    assign rsp_zero  = state == DONE && sum_r == '0;
endmodule

// File: tb/tb_adder_mp_seq.sv
// tb_adder_mp_seq: directed and swept checks of the multi-precision sequencer with a behavioural byte adder
module tb_adder_mp_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        req_valid = 0, req_sub = 0, req_cin = 0, rsp_ready = 0;
    logic [31:0] req_a = 0, req_b = 0;
    logic        req_ready, add_c, add_cout, rsp_valid, rsp_cout, rsp_ovf, rsp_zero, busy;
    logic [7:0]  add_a, add_b, add_s;
    logic [31:0] rsp_sum;
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_c};

    adder_mp_seq #(.NWORDS(4), .IDXW(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
        .req_cin(req_cin), .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b), .add_c(add_c),
        .add_s(add_s), .add_cout(add_cout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero), .busy(busy)
    );

    logic        r2_valid = 0, r2_sub = 0, r2_cin = 0, r2_rdy = 0;
    logic [15:0] r2_a = 0, r2_b = 0, r2_sum;
    logic        r2_req_ready, r2_c, r2_cout_in, r2_rsp_valid, r2_cout, r2_ovf, r2_zero, r2_busy;
    logic [7:0]  r2_aa, r2_ab, r2_s;
    assign {r2_cout_in, r2_s} = {1'b0, r2_aa} + {1'b0, r2_ab} + {8'd0, r2_c};

    adder_mp_seq #(.NWORDS(2), .IDXW(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(r2_valid), .req_ready(r2_req_ready), .req_sub(r2_sub),
        .req_cin(r2_cin), .req_a(r2_a), .req_b(r2_b), .add_a(r2_aa), .add_b(r2_ab), .add_c(r2_c),
        .add_s(r2_s), .add_cout(r2_cout_in), .rsp_valid(r2_rsp_valid), .rsp_ready(r2_rdy),
        .rsp_sum(r2_sum), .rsp_cout(r2_cout), .rsp_ovf(r2_ovf), .rsp_zero(r2_zero), .busy(r2_busy)
    );

    logic         r16_valid = 0, r16_sub = 0, r16_cin = 0, r16_rdy = 0;
    logic [127:0] r16_a = 0, r16_b = 0, r16_sum;
    logic         r16_req_ready, r16_c, r16_cout_in, r16_rsp_valid, r16_cout, r16_ovf, r16_zero, r16_busy;
    logic [7:0]   r16_aa, r16_ab, r16_s;
    assign {r16_cout_in, r16_s} = {1'b0, r16_aa} + {1'b0, r16_ab} + {8'd0, r16_c};

    adder_mp_seq #(.NWORDS(16), .IDXW(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .req_valid(r16_valid), .req_ready(r16_req_ready), .req_sub(r16_sub),
        .req_cin(r16_cin), .req_a(r16_a), .req_b(r16_b), .add_a(r16_aa), .add_b(r16_ab), .add_c(r16_c),
        .add_s(r16_s), .add_cout(r16_cout_in), .rsp_valid(r16_rsp_valid), .rsp_ready(r16_rdy),
        .rsp_sum(r16_sum), .rsp_cout(r16_cout), .rsp_ovf(r16_ovf), .rsp_zero(r16_zero), .busy(r16_busy)
    );

    // Issue one request on the 4-slice unit, wait (bounded) for the response, then take it.
    task automatic run4(input logic sub, input logic cin, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] s, output logic co, output logic ov, output logic z,
                        output int lat);
        req_valid = 1; req_sub = sub; req_cin = cin; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        s = rsp_sum; co = rsp_cout; ov = rsp_ovf; z = rsp_zero;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_ready, rsp_valid, busy, add_a, add_b, add_c, rsp_sum, rsp_cout, rsp_ovf, rsp_zero} !==
            {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset: rdy=%b vld=%b busy=%b a=%h b=%h c=%b sum=%h co=%b ov=%b z=%b, required rdy=1 all else 0",
                     req_ready, rsp_valid, busy, add_a, add_b, add_c, rsp_sum, rsp_cout, rsp_ovf, rsp_zero);
        end
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string name, input logic sub, input logic cin, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] es, input logic eco, input logic eov,
                            input logic ez);
        logic [31:0] s;
        logic co, ov, z;
        int lat;
        run4(sub, cin, a, b, s, co, ov, z, lat);
        checks++;
        if ({s, co, ov, z} !== {es, eco, eov, ez}) begin
            failures++;
            $display("FAIL %s: sum=%h cout=%b ovf=%b zero=%b, required sum=%h cout=%b ovf=%b zero=%b",
                     name, s, co, ov, z, es, eco, eov, ez);
        end
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL %s_latency: %0d edges after accept, required 4", name, lat);
        end
    endtask

    task automatic test_carry_chain();
        check_op("carry_chain", 0, 0, 32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 0, 0, 0);
    endtask

    task automatic test_wrap();
        check_op("full_wrap", 0, 0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1);
        check_op("sub_borrow", 1, 0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 0, 0, 0);
        check_op("sub_equal_cin_ignored", 1, 1, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1, 0, 1);
    endtask

    task automatic test_overflow();
        check_op("signed_ovf", 0, 0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 0);
        check_op("cin_only", 0, 1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 0, 0, 0);
        check_op("sub_neg_ovf", 1, 0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 1, 0);
    endtask

    task automatic test_slices();
        logic [31:0] a, b;
        a = 32'h1122_3344;
        b = 32'h0102_0304;
        req_valid = 1; req_sub = 0; req_cin = 0; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 0; req_a = 32'hDEAD_BEEF; req_b = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({add_a, add_b, add_c} !== {a[8*i +: 8], b[8*i +: 8], 1'b0}) begin
                failures++;
                $display("FAIL slice%0d: a=%h b=%h c=%b, required a=%h b=%h c=0",
                         i, add_a, add_b, add_c, a[8*i +: 8], b[8*i +: 8]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({rsp_valid, rsp_sum} !== {1'b1, 32'h1224_3648}) begin
            failures++;
            $display("FAIL slice_result: valid=%b sum=%h, required valid=1 sum=12243648", rsp_valid, rsp_sum);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic test_back_to_back();
        int lat;
        req_valid = 1; req_sub = 0; req_cin = 0; req_a = 32'd100; req_b = 32'd23;
        @(posedge clk); #1;
        req_a = 32'h10; req_b = 32'h20;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_zero, req_ready, busy} !==
                {1'b1, 32'd123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL hold%0d: valid=%b sum=%h co=%b ov=%b z=%b rdy=%b busy=%b, required valid=1 sum=0000007b flags=0 rdy=0 busy=1",
                         i, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_zero, req_ready, busy);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL release_idle: rdy=%b valid=%b busy=%b, required 1 0 0", req_ready, rsp_valid, busy);
        end
        @(posedge clk); #1;
        req_valid = 0;
        checks++;
        if ({req_ready, busy} !== 2'b01) begin
            failures++;
            $display("FAIL new_accept: rdy=%b busy=%b, required 0 1", req_ready, busy);
        end
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if ({rsp_sum, lat} !== {32'h30, 32'd4}) begin
            failures++;
            $display("FAIL new_result: sum=%h lat=%0d, required sum=00000030 lat=4", rsp_sum, lat);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic test_reset_mid_run();
        req_valid = 1; req_sub = 0; req_cin = 1; req_a = 32'hAAAA_AAAA; req_b = 32'h5555_5555;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, busy, add_a, add_b, add_c, rsp_sum, rsp_cout, rsp_ovf, rsp_zero} !==
            {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset: rdy=%b vld=%b busy=%b a=%h b=%h c=%b sum=%h co=%b, required rdy=1 all else 0",
                     req_ready, rsp_valid, busy, add_a, add_b, add_c, rsp_sum, rsp_cout);
        end
        #2;
        rst_n = 1;
        @(posedge clk); #1;
        check_op("after_reset", 0, 0, 32'd3, 32'd4, 32'd7, 0, 0, 0);
    endtask

    task automatic test_sweep2();
        logic [15:0] a, b, bx;
        logic [16:0] full;
        logic sub, cin, ov;
        int lat;
        for (int k = 0; k < 8; k++) begin
            a = 16'($urandom); b = 16'($urandom);
            sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            if (k == 0) begin a = 16'h8000; b = 16'h0001; sub = 1; end
            if (k == 1) begin a = 16'hFFFF; b = 16'h0000; sub = 0; cin = 1; end
            bx = sub ? ~b : b;
            full = 17'(a) + 17'(bx) + 17'(sub | cin);
            ov = (a[15] == bx[15]) && (full[15] != a[15]);
            r2_valid = 1; r2_sub = sub; r2_cin = cin; r2_a = a; r2_b = b;
            @(posedge clk); #1;
            r2_valid = 0;
            lat = 0;
            while (!r2_rsp_valid && lat < 50) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if ({r2_sum, r2_cout, r2_ovf, r2_zero, lat} !== {full[15:0], full[16], ov, full[15:0] == 16'd0, 32'd2}) begin
                failures++;
                $display("FAIL sweep2_%0d: sum=%h co=%b ov=%b z=%b lat=%0d, required sum=%h co=%b ov=%b z=%b lat=2",
                         k, r2_sum, r2_cout, r2_ovf, r2_zero, lat, full[15:0], full[16], ov, full[15:0] == 16'd0);
            end
            r2_rdy = 1;
            @(posedge clk); #1;
            r2_rdy = 0;
        end
    endtask

    task automatic test_sweep16();
        logic [127:0] a, b, bx;
        logic [128:0] full;
        logic sub, cin, ov;
        int lat;
        for (int k = 0; k < 6; k++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            if (k == 0) begin a = '1; b = 128'd1; sub = 0; cin = 0; end
            bx = sub ? ~b : b;
            full = 129'(a) + 129'(bx) + 129'(sub | cin);
            ov = (a[127] == bx[127]) && (full[127] != a[127]);
            r16_valid = 1; r16_sub = sub; r16_cin = cin; r16_a = a; r16_b = b;
            @(posedge clk); #1;
            r16_valid = 0;
            lat = 0;
            while (!r16_rsp_valid && lat < 50) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if ({r16_sum, r16_cout, r16_ovf, r16_zero, lat} !== {full[127:0], full[128], ov, full[127:0] == 128'd0, 32'd16}) begin
                failures++;
                $display("FAIL sweep16_%0d: sum=%h co=%b ov=%b z=%b lat=%0d, required sum=%h co=%b ov=%b z=%b lat=16",
                         k, r16_sum, r16_cout, r16_ovf, r16_zero, lat, full[127:0], full[128], ov, full[127:0] == 128'd0);
            end
            r16_rdy = 1;
            @(posedge clk); #1;
            r16_rdy = 0;
        end
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_wrap();
        test_overflow();
        test_slices();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep2();
        test_sweep16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
